spi_wrapper: RTL and testbench

//  SPI slave (mode 0, MSB first) in front of a single-port byte RAM.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_ram.sv | 55 +++++
 rtl/spi_wrapper.sv | 101 ++++++++++
 tb/tb_spi_wrapper.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-RAM slave: FSM state encoding, frame command codes
// and the frame length.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_ram.sv
// Single-port byte RAM driven by decoded SPI frames: address loads, data write,
// and a one-cycle tx_valid pulse when a read byte is ready.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic [7:0]           dout_q;
    logic                 tx_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    CMD_WR_ADDR: wr_addr_q <= din[ADDR_SIZE-1:0];
                    CMD_RD_ADDR: rd_addr_q <= din[ADDR_SIZE-1:0];
                    CMD_RD_DATA: begin
                        dout_q     <= mem[rd_addr_q];
                        tx_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rx_valid && din[9:8] == CMD_WR_DATA) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// Mode-0 SPI slave in front of spi_ram: command FSM, 10-bit frame shifter and
// the MSB-first MISO serializer for read-data frames.
module spi_wrapper
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic MOSI,
    input  logic SS_n,
    input  logic clk,
    input  logic rst_n,
    output logic MISO
);

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [9:0] rx_data_q;
    logic       rx_valid_q;
    logic       rd_addr_received_q;
    logic       tx_active_q;
    logic [2:0] tx_cnt_q;
    logic       miso_q;
    logic [7:0] dout;
    logic       tx_valid;

    spi_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (rx_data_q),
        .rx_valid(rx_valid_q),
        .dout    (dout),
        .tx_valid(tx_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            bit_cnt_q          <= '0;
            rx_data_q          <= '0;
            rx_valid_q         <= 1'b0;
            rd_addr_received_q <= 1'b0;
            tx_active_q        <= 1'b0;
            tx_cnt_q           <= '0;
            miso_q             <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                state_q     <= IDLE;
                bit_cnt_q   <= '0;
                tx_active_q <= 1'b0;
                miso_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= CHK_CMD;
                        bit_cnt_q <= '0;
                    end
                    CHK_CMD: begin
                        if (!MOSI)                    state_q <= WRITE;
                        else if (!rd_addr_received_q) state_q <= READ_ADD;
                        else                          state_q <= READ_DATA;
                    end
                    default: begin
                        // Counter parks at the frame length so trailing bits are ignored.
                        if (bit_cnt_q != 4'(FRAME_BITS)) begin
                            rx_data_q  <= {rx_data_q[8:0], MOSI};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            rx_valid_q <= (bit_cnt_q == 4'(FRAME_BITS - 1));
                        end
                        if (state_q == READ_DATA) begin
                            if (tx_active_q) begin
                                if (tx_cnt_q != 3'd0) begin
                                    miso_q   <= dout[tx_cnt_q - 3'd1];
                                    tx_cnt_q <= tx_cnt_q - 3'd1;
                                end else begin
                                    miso_q             <= 1'b0;
                                    tx_active_q        <= 1'b0;
                                    rd_addr_received_q <= 1'b0;
                                end
                            end else if (tx_valid) begin
                                miso_q      <= dout[7];
                                tx_active_q <= 1'b1;
                                tx_cnt_q    <= 3'd7;
                            end
                        end
                    end
                endcase
            end
            if (rx_valid_q && rx_data_q[9:8] == CMD_RD_ADDR) begin
                rd_addr_received_q <= 1'b1;
            end
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_spi_wrapper.sv
// Self-checking bench for spi_wrapper: directed frames followed by random frames
// scored against a transaction-level model of the RAM, address registers and read flag.
module tb_spi_wrapper;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic MOSI  = 1'b0;
    logic SS_n  = 1'b1;
    logic MISO;

    int checks   = 0;
    int failures = 0;

    spi_wrapper #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8)
    ) dut (
        .MOSI (MOSI),
        .SS_n (SS_n),
        .clk  (clk),
        .rst_n(rst_n),
        .MISO (MISO)
    );

    always #5 clk = ~clk;

    int rxv_cnt = 0;
    always @(negedge clk) if (dut.rx_valid_q === 1'b1) rxv_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [7:0]   m_mem   [256];
    bit           m_known [256];
    logic [7:0]   m_wr;
    logic [7:0]   m_rd;
    bit           m_flag;
    int unsigned  known_q [$];

    logic [31:0] obs_vec;
    int          log_n;
    int          rx_pulses;
    logic        miso_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic log_miso();
        obs_vec[log_n] = MISO;
        log_n++;
    endtask

    // One frame: 2 mode cycles, nbits payload bits, extra random bits with SS_n low,
    // then SS_n high for 2 cycles. MISO is logged once per clock after the active edge.
    task automatic run_frame(input logic mode, input logic [9:0] bits, input int nbits,
                             input int extra, input int rst_at);
        int rx0;
        obs_vec = '0;
        log_n   = 0;
        rx0     = rxv_cnt;
        @(negedge clk); SS_n = 1'b0; MOSI = mode;
        @(negedge clk); log_miso(); MOSI = mode;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk); log_miso(); MOSI = bits[9-i];
        end
        for (int i = 0; i < extra; i++) begin
            @(negedge clk); log_miso();
            if (i == rst_at) begin
                rst_n = 1'b0;
                SS_n  = 1'b1;
                #1 miso_rst = MISO;
                break;
            end
            MOSI = 1'($urandom);
        end
        if (rst_at >= 0) begin
            @(negedge clk); rst_n = 1'b1;
        end
        @(negedge clk); log_miso(); SS_n = 1'b1; MOSI = 1'b0;
        @(negedge clk); log_miso();
        @(negedge clk); log_miso();
        rx_pulses = rxv_cnt - rx0;
    endtask

    // Readback byte appears on MISO from the 14th logged cycle onward, MSB first.
    function automatic logic [31:0] exp_stream(input bit rb, input logic [7:0] b);
        logic [31:0] e;
        e = '0;
        if (rb) for (int k = 0; k < 8; k++) e[13+k] = b[7-k];
        return e;
    endfunction

    task automatic model_reset();
        m_wr   = 8'h00;
        m_rd   = 8'h00;
        m_flag = 1'b0;
    endtask

    task automatic model_frame(input logic mode, input logic [9:0] bits,
                               output bit rb, output logic [7:0] rb_byte);
        logic [7:0] p;
        p       = bits[7:0];
        rb      = 1'b0;
        rb_byte = 8'h00;
        case (bits[9:8])
            2'b00: m_wr = p;
            2'b01: begin
                m_mem[m_wr] = p;
                if (!m_known[m_wr]) begin
                    m_known[m_wr] = 1'b1;
                    known_q.push_back(int'(m_wr));
                end
            end
            2'b10: begin
                m_rd   = p;
                m_flag = 1'b1;
            end
            default: begin
                if (mode && m_flag) begin
                    rb      = 1'b1;
                    rb_byte = m_mem[m_rd];
                    m_flag  = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_wr_addr"}, 32'(dut.ram.wr_addr_q), 32'(m_wr));
        check({tag, "_rd_addr"}, 32'(dut.ram.rd_addr_q), 32'(m_rd));
        check({tag, "_flag"}, 32'(dut.rd_addr_received_q), 32'(m_flag));
        check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        bit          rb;
        logic [7:0]  rb_byte;
        logic        mode;
        logic [9:0]  bits;
        int          extra;

        for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
        model_reset();

        // Reset
        repeat (2) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_bitcnt", 32'(dut.bit_cnt_q), 32'h0);
        check("rst_rx_valid", 32'(dut.rx_valid_q), 32'h0);
        check("rst_tx_valid", 32'(dut.tx_valid), 32'h0);
        check("rst_dout", 32'(dut.dout), 32'h0);
        check_regs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write address 0xFF
        model_frame(1'b0, 10'b0011111111, rb, rb_byte);
        run_frame(1'b0, 10'b0011111111, 10, 0, -1);
        check("t1_wr_addr", 32'(dut.ram.wr_addr_q), 32'hFF);
        check("t1_miso", obs_vec, 32'h0);
        check("t1_rx_pulses", 32'(rx_pulses), 32'd1);

        // 2: write data 0x55
        model_frame(1'b0, 10'b0101010101, rb, rb_byte);
        run_frame(1'b0, 10'b0101010101, 10, 2, -1);
        check("t2_mem_ff", 32'(dut.ram.mem[255]), 32'h55);
        check("t2_miso", obs_vec, 32'h0);

        // 3: read address 0xFF
        model_frame(1'b1, 10'b1011111111, rb, rb_byte);
        run_frame(1'b1, 10'b1011111111, 10, 0, -1);
        check("t3_rd_addr", 32'(dut.ram.rd_addr_q), 32'hFF);
        check("t3_flag", 32'(dut.rd_addr_received_q), 32'h1);

        // 4: read data -> 0x55 on MISO
        model_frame(1'b1, 10'b1100111011, rb, rb_byte);
        run_frame(1'b1, 10'b1100111011, 10, 10, -1);
        check("t4_miso_stream", obs_vec, exp_stream(1'b1, 8'h55));
        check("t4_flag", 32'(dut.rd_addr_received_q), 32'h0);
        check("t4_rx_pulses", 32'(rx_pulses), 32'd1);

        // 5: abort a write-data frame after 5 bits
        run_frame(1'b0, 10'b0100000000, 5, 0, -1);
        check("t5_rx_pulses", 32'(rx_pulses), 32'd0);
        check("t5_state", 32'(dut.state_q), 32'(IDLE));
        check("t5_mem_ff", 32'(dut.ram.mem[255]), 32'h55);
        check("t5_wr_addr", 32'(dut.ram.wr_addr_q), 32'hFF);

        // 6: reset during readback bit 3
        model_frame(1'b1, 10'b1011111111, rb, rb_byte);
        run_frame(1'b1, 10'b1011111111, 10, 0, -1);
        run_frame(1'b1, 10'b1100000000, 10, 10, 5);
        model_reset();
        check("t6_bit3_before_rst", 32'(obs_vec[16]), 32'h1);
        check("t6_miso_at_rst", 32'(miso_rst), 32'h0);
        check("t6_mem_ff", 32'(dut.ram.mem[255]), 32'h55);
        check_regs("t6");

        // Random frames against the model
        for (int it = 0; it < 40; it++) begin
            mode = 1'($urandom);
            bits = 10'($urandom);
            if (bits[9:8] == 2'b10)
                bits[7:0] = 8'(known_q[$urandom_range(0, known_q.size() - 1)]);
            model_frame(mode, bits, rb, rb_byte);
            extra = rb ? int'($urandom_range(10, 12)) : int'($urandom_range(0, 12));
            run_frame(mode, bits, 10, extra, -1);
            check("rnd_miso_stream", obs_vec, exp_stream(rb, rb_byte));
            check("rnd_rx_pulses", 32'(rx_pulses), 32'd1);
            check_regs("rnd");
        end

        foreach (known_q[i])
            check("final_mem", 32'(dut.ram.mem[known_q[i]]), 32'(m_mem[known_q[i]]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
